// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared widths and digit types for the 22x16 approximate multiplier
package approx_mult_pkg;
  localparam int A_W = 22;
  localparam int B_W = 16;
  localparam int P_W = A_W + B_W;
  localparam int NA = A_W / 2;
  localparam int NB = B_W / 2;
  typedef logic [1:0] digit_t;
  typedef logic [3:0] pp_t;
endpackage

// File: rtl/kulkarni_2x2.sv
// kulkarni_2x2: 2x2 unsigned digit multiplier, approximating 3*3 as 7 when not precise
module kulkarni_2x2
  import approx_mult_pkg::*;
(
  input  digit_t x,
  input  digit_t y,
  input  logic   precise_en,
  output pp_t    p
);
  assign p = (!precise_en && &x && &y) ? 4'd7 : pp_t'(x) * pp_t'(y);
endmodule

// File: rtl/approx_mult_22x16_signed.sv
// approx_mult_22x16_signed: registered signed multiplier with selectable Kulkarni approximation
module approx_mult_22x16_signed
  import approx_mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [A_W-1:0]   a1,
  input  logic [B_W-1:0]   b1,
  input  logic             precise_en,
  output logic [P_W-1:0]   product
);
  logic           sign;
  logic [A_W-1:0] a_mag;
  logic [B_W-1:0] b_mag;
  logic [P_W-2:0] m;
  pp_t            pp [NA][NB];
  assign sign  = a1[A_W-1] ^ b1[B_W-1];
  // Negating the most negative value wraps to exactly 2^(W-1) as an unsigned magnitude
  assign a_mag = a1[A_W-1] ? -a1 : a1;
  assign b_mag = b1[B_W-1] ? -b1 : b1;
  for (genvar i = 0; i < NA; i++) begin : g_a
    for (genvar j = 0; j < NB; j++) begin : g_b
      kulkarni_2x2 u_blk (
        .x          (a_mag[2*i +: 2]),
        .y          (b_mag[2*j +: 2]),
        .precise_en (precise_en),
        .p          (pp[i][j])
      );
    end
  end
  always_comb begin
    m = '0;
    for (int i = 0; i < NA; i++)
      for (int j = 0; j < NB; j++)
        m = m + ((P_W-1)'(pp[i][j]) << (2 * (i + j)));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) product <= '0;
    else        product <= sign ? -{1'b0, m} : {1'b0, m};
endmodule

// File: tb/tb_approx_mult_22x16_signed.sv
// tb_approx_mult_22x16_signed: pipelined random and directed checks against an arithmetic model
module tb_approx_mult_22x16_signed;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [21:0] a1 = '0;
  logic [15:0] b1 = '0;
  logic        precise_en = 1;
  logic [37:0] product;
  int n_checks = 0;
  int n_err = 0;
  bit          have_prev = 0;
  bit          prev_pe;
  longint      prev_exp, prev_exact;
  string       prev_tag;

  approx_mult_22x16_signed dut (
    .clk(clk), .rst_n(rst_n), .a1(a1), .b1(b1),
    .precise_en(precise_en), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Exact product minus 2*weight for every (3,3) digit pair in approximate mode
  function automatic longint model(input longint a, input longint b, input bit pe);
    longint ma = a < 0 ? -a : a;
    longint mb = b < 0 ? -b : b;
    longint m = ma * mb;
    if (!pe)
      for (int i = 0; i < 11; i++)
        for (int j = 0; j < 8; j++)
          if (((ma >> (2*i)) & 3) == 3 && ((mb >> (2*j)) & 3) == 3)
            m -= longint'(2) << (2*(i+j));
    return ((a < 0) ^ (b < 0)) ? -m : m;
  endfunction

  function automatic longint labs(input longint v);
    return v < 0 ? -v : v;
  endfunction

  task automatic check_prev();
    logic signed [63:0] got = $signed(product);
    check(prev_tag, got, prev_exp);
    if (!prev_pe) begin
      check({prev_tag, "_bound"}, longint'(labs(got) <= labs(prev_exact)), 1);
      if (got != 0) check({prev_tag, "_sign"}, longint'(got < 0), longint'(prev_exact < 0));
    end
  endtask

  task automatic drive(input longint a, input longint b, input bit pe, input string tag);
    @(negedge clk);
    if (have_prev) check_prev();
    a1 = 22'(a);
    b1 = 16'(b);
    precise_en = pe;
    prev_exp = model(a, b, pe);
    prev_exact = a * b;
    prev_pe = pe;
    prev_tag = tag;
    have_prev = 1;
  endtask

  initial begin
    logic signed [21:0] ra;
    logic signed [15:0] rb;
    #3 check("reset", $signed(product), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    drive(-2, -2, 1, "neg2x2");
    drive(3, 3, 1, "p3x3");
    drive(3, 3, 0, "a3x3");
    drive(-3, 3, 0, "an3x3");
    drive(15, 15, 0, "a15x15");
    drive(15, 15, 1, "p15x15");
    drive(-2097152, -32768, 1, "cmin_min");
    drive(2097151, -32768, 1, "cmax_min");
    drive(-2097152, -32768, 0, "amin_min");
    drive(2097151, 32767, 0, "amax_max");
    for (int i = 0; i < 8; i++) begin
      rb = 16'($urandom);
      drive(0, rb, i[0], "zero_a");
    end
    for (int a = -2; a <= 2; a++)
      for (int b = -2; b <= 255; b++)
        drive(a, b, 1, "sweep");
    // Asynchronous clear between edges discards the pending result
    drive(1234, -77, 0, "pre_rst");
    @(posedge clk);
    #2 rst_n = 0;
    #1 check("rst_async", $signed(product), 0);
    have_prev = 0;
    @(negedge clk);
    check("rst_hold", $signed(product), 0);
    rst_n = 1;
    drive(5, 6, 1, "post_rst");
    for (int i = 0; i < 3000; i++) begin
      ra = 22'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) begin
        ra = ra | 22'h0F0F3;
        rb = rb | 16'h0303;
      end
      drive(ra, rb, ($urandom % 4) == 0, i % 2 ? "rnd" : "rnd_o");
    end
    @(negedge clk);
    if (have_prev) check_prev();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
